bin_to_bcd: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It produces the packed BCD digit vectors that the display and zero-detect paths consume, so it sits upstream of every per-digit BCD consumer. The handshake is a simple start/done pair. The result is held stable in an output register until the next conversion completes.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_add3.sv | 20 ++
 rtl/bin_to_bcd.sv | 92 +++++++++
 tb/tb_bin_to_bcd.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and sizing helper for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned ADD3_THRESHOLD = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of decimal digits needed to hold the largest value of a w-bit unsigned number.
  function automatic int unsigned digits_for_width(input int unsigned w);
    logic [63:0] v;
    int unsigned n;
    v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    n = 0;
    do begin
      v = v / 64'd10;
      n = n + 1;
    end while (v != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  input  logic                   unused_tie,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  logic tie_sink;

  always_comb begin
    tie_sink  = unused_tie;
    digit_out = digit_in;
    if (digit_in >= BCD_DIGIT_W'(ADD3_THRESHOLD)) begin
      digit_out = digit_in + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a start/done handshake and a held result register.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 8,
  parameter int unsigned DIGITS    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_WIDTH-1:0]          bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          zero,
  output logic                          overflow
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  state_t               state;
  logic [BIN_WIDTH-1:0] shreg;
  logic [BCD_W-1:0]     work;
  logic [BCD_W-1:0]     corr;
  logic [BCD_W-1:0]     shifted;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_acc;
  logic                 carry_out;
  logic                 last_shift;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in   (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .unused_tie (1'b0),
      .digit_out  (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits shifted up by one, binary MSB entering digit 0.
  always_comb begin
    shifted    = {corr[BCD_W-2:0], shreg[BIN_WIDTH-1]};
    carry_out  = corr[BCD_W-1];
    last_shift = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            work    <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(BIN_WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          work    <= shifted;
          ovf_acc <= ovf_acc | carry_out;
          cnt     <= cnt - CNT_W'(1);
          if (last_shift) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= shifted;
            zero     <= (shifted == '0);
            overflow <= ovf_acc | carry_out;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed table, full sweep, random values
// on a two-digit instance, and handshake/reset corner sequences.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  bin1 = '0, bin2 = '0;
  logic        busy1, done1, zero1, ovf1;
  logic        busy2, done2, zero2, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_bcd #(.BIN_WIDTH(8), .DIGITS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .zero(zero1), .overflow(ovf1)
  );

  bin_to_bcd #(.BIN_WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .zero(zero2), .overflow(ovf2)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp_bcd;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on value mod 10^digits.
  function automatic logic [11:0] model_bcd(input int v, input int digits);
    int p, m;
    logic [11:0] r;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    m = v % p;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v, input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return v >= p;
  endfunction

  // One conversion on instance sel; lat counts cycles after the accepting edge until done.
  task automatic run(input int sel, input logic [7:0] v, output int lat, output int busy_cyc,
                     output logic [11:0] got_bcd, output logic got_zero, output logic got_ovf);
    @(negedge clk);
    if (sel == 1) begin start1 = 1'b1; bin1 = v; end
    else          begin start2 = 1'b1; bin2 = v; end
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    bin1 = 8'h5a; bin2 = 8'ha5;
    lat = -1; busy_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if ((sel == 1) ? done1 : done2) begin lat = i; break; end
      if ((sel == 1) ? busy1 : busy2) busy_cyc++;
      @(negedge clk);
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout waiting for done on dut%0d bin=%0d", sel, v);
    end
    got_bcd  = (sel == 1) ? bcd1 : {4'h0, bcd2};
    got_zero = (sel == 1) ? zero1 : zero2;
    got_ovf  = (sel == 1) ? ovf1 : ovf2;
  endtask

  initial begin
    vec_t        vecs[7];
    int          lat, bc, dones;
    logic [11:0] gb;
    logic        gz, go;
    logic [7:0]  r;

    vecs[0] = '{8'd0,   12'h000, 1'b1, 1'b0};
    vecs[1] = '{8'd255, 12'h255, 1'b0, 1'b0};
    vecs[2] = '{8'd99,  12'h099, 1'b0, 1'b0};
    vecs[3] = '{8'd10,  12'h010, 1'b0, 1'b0};
    vecs[4] = '{8'd200, 12'h200, 1'b0, 1'b0};
    vecs[5] = '{8'd1,   12'h001, 1'b0, 1'b0};
    vecs[6] = '{8'd109, 12'h109, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_done", 32'(done1), 32'd0);
    check("reset_bcd", 32'(bcd1), 32'd0);
    check("reset_zero", 32'(zero1), 32'd1);
    check("reset_ovf", 32'(ovf1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run(1, vecs[i].bin, lat, bc, gb, gz, go);
      check("tbl_latency", 32'(lat), 32'd8);
      check("tbl_busy_cycles", 32'(bc), 32'd8);
      check("tbl_bcd", 32'(gb), 32'(vecs[i].exp_bcd));
      check("tbl_zero", 32'(gz), 32'(vecs[i].exp_zero));
      check("tbl_ovf", 32'(go), 32'(vecs[i].exp_ovf));
      @(negedge clk);
      check("tbl_done_one_cycle", 32'(done1), 32'd0);
    end

    // Full sweep of the 3-digit instance
    for (int v = 0; v < 256; v++) begin
      run(1, 8'(v), lat, bc, gb, gz, go);
      check("sweep_bcd", 32'(gb), 32'(model_bcd(v, 3)));
      check("sweep_zero", 32'(gz), 32'(v == 0));
    end

    // Two-digit instance: directed overflow cases then random values
    run(2, 8'd123, lat, bc, gb, gz, go);
    check("d2_123_bcd", 32'(gb), 32'h23);
    check("d2_123_ovf", 32'(go), 32'd1);
    run(2, 8'd99, lat, bc, gb, gz, go);
    check("d2_99_bcd", 32'(gb), 32'h99);
    check("d2_99_ovf", 32'(go), 32'd0);
    run(2, 8'd100, lat, bc, gb, gz, go);
    check("d2_100_zero", 32'(gz), 32'd1);
    check("d2_100_ovf", 32'(go), 32'd1);
    for (int i = 0; i < 40; i++) begin
      r = 8'($urandom_range(0, 255));
      run(2, r, lat, bc, gb, gz, go);
      check("d2_rand_bcd", 32'(gb), 32'(model_bcd(int'(r), 2)));
      check("d2_rand_ovf", 32'(go), 32'(model_ovf(int'(r), 2)));
      check("d2_rand_zero", 32'(gz), 32'(model_bcd(int'(r), 2) == 12'h0));
    end

    // Start during a conversion is ignored and not queued
    @(negedge clk); start1 = 1'b1; bin1 = 8'd37;
    @(negedge clk); start1 = 1'b0; bin1 = 8'd0;
    repeat (3) @(negedge clk);
    start1 = 1'b1; bin1 = 8'd200;
    @(negedge clk); start1 = 1'b0;
    dones = 0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done1) begin dones++; if (lat < 0) begin gb = bcd1; lat = i; end end
      @(negedge clk);
    end
    check("ignored_start_dones", 32'(dones), 32'd1);
    check("ignored_start_bcd", 32'(gb), 32'h037);
    check("ignored_start_busy", 32'(busy1), 32'd0);

    // Start held high: next acceptance lands in the done cycle
    @(negedge clk); start1 = 1'b1; bin1 = 8'd10;
    @(negedge clk); bin1 = 8'd200;
    lat = -1; bc = -1;
    for (int i = 0; i < 30; i++) begin
      if (done1 && lat < 0) begin
        lat = i;
        check("b2b_first_bcd", 32'(bcd1), 32'h010);
      end else if (done1 && bc < 0) begin
        bc = i;
        check("b2b_second_bcd", 32'(bcd1), 32'h200);
        start1 = 1'b0;
        break;
      end else if (lat >= 0 && i == lat + 4) begin
        check("b2b_hold_bcd", 32'(bcd1), 32'h010);
        check("b2b_busy_second", 32'(busy1), 32'd1);
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    check("b2b_first_latency", 32'(lat), 32'd8);
    check("b2b_spacing", 32'(bc - lat), 32'd9);
    repeat (3) @(negedge clk);

    // Reset mid-conversion aborts with outputs at reset values
    @(negedge clk); start1 = 1'b1; bin1 = 8'd77;
    @(negedge clk); start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy1), 32'd0);
    check("rst_mid_bcd", 32'(bcd1), 32'd0);
    check("rst_mid_zero", 32'(zero1), 32'd1);
    check("rst_mid_done", 32'(done1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done1) dones++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);
    run(1, 8'd42, lat, bc, gb, gz, go);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_bcd", 32'(gb), 32'h042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
